ex_flag_stage: RTL and testbench
================================

Name: ex_flag_stage

Overview:
- Execute-stage back end. It sits directly downstream of the combinational ALU.
- Captures the ALU result and Z/OV/N each cycle and holds the architectural flag register.
- Applies per-opcode flag-update rules and evaluates branch conditions against the flags.
- Passes result, destination register and branch decision to the memory stage through a 2-entry skid buffer with a valid/ready handshake and a flush.

Parameters:
- DW, 16, datapath width of the ALU result.
- RW, 4, register-file index width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset is asynchronous and active-low.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_full.
- alu_result  in  DW  ALU Result.
- alu_z, alu_ov, alu_n  in  1 each  ALU flags.
- alu_op  in  3  ALU Opcode: add=000, sub=001, xor=010, sll=011, srl=100, sra=101, ll=110, lh=111.
- is_alu  in  1  instruction is an ALU op; enables the flag-update rules.
- dst  in  RW  destination register index.
- reg_we  in  1  instruction writes a register.
- br_en  in  1  instruction is a conditional branch.
- br_cond  in  3  branch condition code.
- flush  in  1  squash the stage's contents and the current input.
- out_valid  out  1  output entry valid.
- out_ready  in  1  memory stage accepts.
- out_result  out  DW  registered result.
- out_dst  out  RW  registered destination.
- out_we  out  1  registered write enable.
- out_br_taken  out  1  branch decision, aligned with out_valid.
- flag_z, flag_ov, flag_n  out  1 each  architectural flag register.

Behaviour:
- Reset (async, rst_n=0): both buffer entries invalid; out_valid=0, in_ready=0 while rst_n=0 and 1 from the first clock edge after release; out_result=0, out_dst=0, out_we=0, out_br_taken=0; flags=0.
- Accept condition: acc = in_valid & in_ready & !flush.
- Latency: an accepted instruction appears on out_* the next cycle when the output entry is empty or being drained. Throughput is 1 per cycle.
- Skid buffer states: EMPTY, ONE (main valid), FULL (main + skid valid).
  - EMPTY -acc-> ONE.
  - ONE: acc & out_ready -> ONE (replace); acc & !out_ready -> FULL (input to skid); !acc & out_ready -> EMPTY.
  - FULL: out_ready -> ONE (skid moves to main); in_ready=0 so there is no accept.
- Order is strictly FIFO; no entry is lost or duplicated under any out_ready pattern.
- Flag update on acc & is_alu only:
  - add/sub write Z, OV, N.
  - xor/sll/srl/sra write Z and N; OV is held.
  - ll/lh write no flags.
  - Non-ALU instructions never write flags.
- Branch evaluation on acc & br_en uses the flag register value before this cycle's update. Branches are never ALU ops.
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: N | Z
  - 110 OV: OV
  - 111 always: 1
- br_en=0 gives out_br_taken=0. The decision is stored with the entry.
- Flush: on the next edge both entries are invalidated and out_valid=0. The input in that cycle is dropped and its flags are not written. Flags already committed are kept.
- Flush together with out_ready: flush wins; nothing is reported as transferred beyond the current handshake.
- out_we and out_br_taken are meaningful only while out_valid=1, and are forced to 0 when invalid.
- Reset asserted mid-operation returns every output to its reset value immediately.

Decomposition:
- Shared package/include holds:
  - ALU opcode localparams (same encodings as the ALU).
  - Branch condition codes.
  - The per-opcode flag-write mask (3 bits {Z,OV,N} per opcode).
- One sub-module: ex_skid_buf, a generic 2-entry skid buffer parameterised by payload width. Its payload is {result, dst, we, br_taken}.
- Flag register and condition logic stay in ex_flag_stage.

Test Plan:
- Reset: assert rst_n=0 mid-stream with both entries full -> out_valid=0, flags=000 immediately; in_ready=1 one edge after release.
- Flag rules:
  - add with alu_z=0, alu_ov=1, alu_n=1 -> flags Z/OV/N=0/1/1.
  - Then xor with z=1, ov=0, n=0 -> flags 1/1/0 (OV held).
  - Then ll with z=0 -> flags unchanged 1/1/0.
- Branch:
  - After sub sets Z=1, N=0: br_cond=001 -> out_br_taken=1; br_cond=010 -> 0; br_cond=100 -> 1.
  - br_en=0 with br_cond=111 -> 0.
- Backpressure: stream results 0x0001..0x0008 every cycle, out_ready toggled 1,0,0,1,... -> output sequence exactly 0x0001..0x0008 in order; in_ready=0 only while both entries are valid.
- Flush:
  - With two entries held and in_valid=1 (add, ov=1), assert flush -> next cycle out_valid=0 and flag_ov unchanged.
  - Next instruction 0x00AA emerges after 1 cycle.
- Simultaneous: FULL state, out_ready=1 and in_valid=1 in the same cycle -> skid entry moves to main, input is not accepted (in_ready=0), and it is accepted on the following cycle.

Source files
------------

// File: rtl/ex_flag_stage_pkg.sv
// Shared definitions for the execute-stage back end.
//   - ALU opcode encodings (identical to the ALU's own)
//   - branch condition codes
//   - per-opcode flag-write mask, bit order {Z, OV, N}
//   - skid buffer occupancy states
package ex_flag_stage_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_LL  = 3'b110;
  localparam logic [2:0] OP_LH  = 3'b111;

  localparam logic [2:0] BR_NE  = 3'b000;
  localparam logic [2:0] BR_EQ  = 3'b001;
  localparam logic [2:0] BR_GT  = 3'b010;
  localparam logic [2:0] BR_LT  = 3'b011;
  localparam logic [2:0] BR_GE  = 3'b100;
  localparam logic [2:0] BR_LE  = 3'b101;
  localparam logic [2:0] BR_OV  = 3'b110;
  localparam logic [2:0] BR_AL  = 3'b111;

  localparam logic [2:0] FM_NONE = 3'b000;
  localparam logic [2:0] FM_ZN   = 3'b101;
  localparam logic [2:0] FM_ZON  = 3'b111;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Which flags an ALU opcode is allowed to write, {Z, OV, N}.
  function automatic logic [2:0] flag_wmask(input logic [2:0] op);
    logic [2:0] m;
    unique case (op)
      OP_ADD, OP_SUB:                 m = FM_ZON;
      OP_XOR, OP_SLL, OP_SRL, OP_SRA: m = FM_ZN;
      default:                        m = FM_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready handshake and flush.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_push         upstream entry accepted this cycle (already qualified
//                  with o_in_ready and flush by the owner)
//   i_data         payload to store on i_push
//   i_flush        invalidate both entries on the next edge
//   i_out_ready    downstream accepts the head entry
//   o_in_ready     registered, 1 unless both entries are valid
//   o_out_valid    head entry valid
//   o_data         head entry payload
module ex_skid_buf
  import ex_flag_stage_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [PW-1:0] i_data,
  input  logic          i_flush,
  input  logic          i_out_ready,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [PW-1:0] o_data
);

  skid_state_e   r_state;
  skid_state_e   w_next;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_in_ready;
  logic          w_load_main;
  logic          w_load_skid;
  logic          w_skid_to_main;

  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (i_flush) begin
      w_next = SKID_EMPTY;
    end else begin
      unique case (r_state)
        SKID_EMPTY: begin
          if (i_push) begin
            w_next      = SKID_ONE;
            w_load_main = 1'b1;
          end
        end
        SKID_ONE: begin
          if (i_push && i_out_ready) begin
            w_load_main = 1'b1;
          end else if (i_push) begin
            w_next      = SKID_FULL;
            w_load_skid = 1'b1;
          end else if (i_out_ready) begin
            w_next = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // o_in_ready is low here, so i_push cannot occur.
          if (i_out_ready) begin
            w_next         = SKID_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_next = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SKID_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      // Ready is registered from the next occupancy so it never depends
      // combinationally on i_out_ready.
      r_in_ready <= (w_next != SKID_FULL);
      if (w_load_main) begin
        r_main <= i_data;
      end else if (w_skid_to_main) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = (r_state != SKID_EMPTY);
  assign o_data      = r_main;

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: captures the ALU result, maintains the
// architectural Z/OV/N flag register, evaluates branch conditions and
// forwards {result, dst, we, br_taken} through a 2-entry skid buffer.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid / in_ready         upstream handshake (in_ready registered)
//   alu_result, alu_z/ov/n      ALU outputs
//   alu_op, is_alu              opcode and ALU-instruction qualifier
//   dst, reg_we                 destination register and write enable
//   br_en, br_cond              conditional branch and condition code
//   flush                       squash buffered entries and current input
//   out_valid / out_ready       downstream handshake
//   out_result, out_dst         head entry payload
//   out_we, out_br_taken        head entry controls, 0 when invalid
//   flag_z, flag_ov, flag_n     architectural flags
module ex_flag_stage
  import ex_flag_stage_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_z,
  input  logic          alu_ov,
  input  logic          alu_n,
  input  logic [2:0]    alu_op,
  input  logic          is_alu,
  input  logic [RW-1:0] dst,
  input  logic          reg_we,
  input  logic          br_en,
  input  logic [2:0]    br_cond,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dst,
  output logic          out_we,
  output logic          out_br_taken,
  output logic          flag_z,
  output logic          flag_ov,
  output logic          flag_n
);

  localparam int unsigned PW = DW + RW + 2;

  logic          r_flag_z;
  logic          r_flag_ov;
  logic          r_flag_n;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_cond;
  logic [2:0]    w_wmask;
  logic [PW-1:0] w_payload;
  logic [PW-1:0] w_head;
  logic          w_out_valid;

  assign w_acc   = in_valid & w_in_ready & ~flush;
  assign w_wmask = flag_wmask(alu_op);

  // Condition is evaluated on the flags as they stand before this
  // cycle's update.
  always_comb begin
    w_cond = 1'b0;
    unique case (br_cond)
      BR_NE:   w_cond = ~r_flag_z;
      BR_EQ:   w_cond = r_flag_z;
      BR_GT:   w_cond = ~r_flag_z & ~r_flag_n;
      BR_LT:   w_cond = r_flag_n;
      BR_GE:   w_cond = r_flag_z | ~r_flag_n;
      BR_LE:   w_cond = r_flag_n | r_flag_z;
      BR_OV:   w_cond = r_flag_ov;
      BR_AL:   w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z  <= 1'b0;
      r_flag_ov <= 1'b0;
      r_flag_n  <= 1'b0;
    end else if (w_acc && is_alu) begin
      if (w_wmask[2]) r_flag_z  <= alu_z;
      if (w_wmask[1]) r_flag_ov <= alu_ov;
      if (w_wmask[0]) r_flag_n  <= alu_n;
    end
  end

  assign w_payload = {alu_result, dst, reg_we, br_en & w_cond};

  ex_skid_buf #(
    .PW (PW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_acc),
    .i_data      (w_payload),
    .i_flush     (flush),
    .i_out_ready (out_ready),
    .o_in_ready  (w_in_ready),
    .o_out_valid (w_out_valid),
    .o_data      (w_head)
  );

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_result   = w_head[PW-1 -: DW];
  assign out_dst      = w_head[RW+1 : 2];
  assign out_we       = w_out_valid & w_head[1];
  assign out_br_taken = w_out_valid & w_head[0];
  assign flag_z       = r_flag_z;
  assign flag_ov      = r_flag_ov;
  assign flag_n       = r_flag_n;

endmodule

// File: tb/tb_ex_flag_stage.sv
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_result;
  logic        alu_z, alu_ov, alu_n;
  logic [2:0]  alu_op;
  logic        is_alu;
  logic [3:0]  dst;
  logic        reg_we;
  logic        br_en;
  logic [2:0]  br_cond;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_we;
  logic        out_br_taken;
  logic        flag_z, flag_ov, flag_n;

  ex_flag_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_z(alu_z), .alu_ov(alu_ov), .alu_n(alu_n),
    .alu_op(alu_op), .is_alu(is_alu), .dst(dst), .reg_we(reg_we),
    .br_en(br_en), .br_cond(br_cond), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_we(out_we), .out_br_taken(out_br_taken),
    .flag_z(flag_z), .flag_ov(flag_ov), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  dst;
    logic        we;
    logic        br;
  } ent_t;

  // Reference model: FIFO of at most two entries plus flag variables.
  ent_t        q[$];
  logic [15:0] xfers[$];
  logic        mz, mov, mn;
  logic        m_rdy;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic br_model(input logic [2:0] c);
    case (c)
      3'd0:    return !mz;
      3'd1:    return mz;
      3'd2:    return !mz && !mn;
      3'd3:    return mn;
      3'd4:    return mz || !mn;
      3'd5:    return mn || mz;
      3'd6:    return mov;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_dst", out_dst, q[0].dst);
      chk("out_we", out_we, q[0].we);
      chk("out_br_taken", out_br_taken, q[0].br);
    end else begin
      chk("out_we_idle", out_we, 0);
      chk("out_br_idle", out_br_taken, 0);
    end
    chk("flags", {flag_z, flag_ov, flag_n}, {mz, mov, mn});
  endtask

  // Called at a negedge with inputs already driven; advances one cycle.
  task automatic step();
    ent_t e;
    logic acc;
    #1;
    if (out_valid && out_ready) xfers.push_back(out_result);
    acc = in_valid && m_rdy && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        e.res = alu_result;
        e.dst = dst;
        e.we  = reg_we;
        e.br  = br_en && br_model(br_cond);
        q.push_back(e);
      end
    end
    if (acc && is_alu) begin
      if (alu_op == 3'd0 || alu_op == 3'd1) begin
        mz = alu_z; mov = alu_ov; mn = alu_n;
      end else if (alu_op != 3'd6 && alu_op != 3'd7) begin
        mz = alu_z; mn = alu_n;
      end
    end
    m_rdy = (q.size() < 2);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] zon,
                       input logic [2:0] op, input logic alu, input logic [3:0] d,
                       input logic we, input logic be, input logic [2:0] bc);
    in_valid   = v;
    alu_result = r;
    {alu_z, alu_ov, alu_n} = zon;
    alu_op     = op;
    is_alu     = alu;
    dst        = d;
    reg_we     = we;
    br_en      = be;
    br_cond    = bc;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  // Fill both entries with non-ALU instructions while downstream stalls.
  task automatic fill_full(input logic [15:0] a, input logic [15:0] b);
    out_ready = 1'b0;
    flush = 1'b0;
    drive(1'b1, a, 3'b000, 3'b000, 1'b0, 4'h1, 1'b1, 1'b0, 3'b000);
    step();
    drive(1'b1, b, 3'b000, 3'b000, 1'b0, 4'h2, 1'b1, 1'b0, 3'b000);
    step();
  endtask

  task automatic reset_check();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {flag_z, flag_ov, flag_n}, 3'b000);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_result", out_result, 16'h0);
    chk("rst_out_dst", out_dst, 4'h0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_br", out_br_taken, 0);
    q.delete();
    mz = 1'b0; mov = 1'b0; mn = 1'b0;
    m_rdy = 1'b0;
    idle();
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_release_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          idx;
    int          cyc;
    logic [15:0] r16;
    logic        be;

    rst_n = 1'b0;
    idle();
    flush = 1'b0;
    out_ready = 1'b0;
    mz = 1'b0; mov = 1'b0; mn = 1'b0;
    m_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 0);
    chk("init_flags", {flag_z, flag_ov, flag_n}, 3'b000);
    rst_n = 1'b1;
    step();
    chk("init_ready_after_release", in_ready, 1);

    // Flag rules
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 3'b011, 3'b000, 1'b1, 4'h3, 1'b1, 1'b0, 3'b000);
    step();
    chk("flags_add", {flag_z, flag_ov, flag_n}, 3'b011);
    drive(1'b1, 16'h0000, 3'b100, 3'b010, 1'b1, 4'h3, 1'b1, 1'b0, 3'b000);
    step();
    chk("flags_xor", {flag_z, flag_ov, flag_n}, 3'b110);
    drive(1'b1, 16'h5600, 3'b000, 3'b110, 1'b1, 4'h4, 1'b1, 1'b0, 3'b000);
    step();
    chk("flags_ll", {flag_z, flag_ov, flag_n}, 3'b110);

    // Branches after sub sets Z=1, OV=0, N=0
    drive(1'b1, 16'h0000, 3'b100, 3'b001, 1'b1, 4'h5, 1'b1, 1'b0, 3'b000);
    step();
    chk("flags_sub", {flag_z, flag_ov, flag_n}, 3'b100);
    drive(1'b1, 16'h0010, 3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 3'b001);
    step();
    chk("br_eq", out_br_taken, 1);
    drive(1'b1, 16'h0011, 3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 3'b010);
    step();
    chk("br_gt", out_br_taken, 0);
    drive(1'b1, 16'h0012, 3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 3'b100);
    step();
    chk("br_ge", out_br_taken, 1);
    drive(1'b1, 16'h0013, 3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, 3'b111);
    step();
    chk("br_disabled", out_br_taken, 0);
    drain();

    // Backpressure stream 1..8 with out_ready pattern 1,0,0,1
    xfers.delete();
    idx = 1;
    cyc = 0;
    while (xfers.size() < 8 && cyc < 60) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (idx <= 8) begin
        drive(1'b1, idx[15:0], 3'b000, 3'b000, 1'b0, idx[3:0], 1'b1, 1'b0, 3'b000);
        if (m_rdy) idx++;
      end else begin
        idle();
      end
      step();
      cyc++;
    end
    chk("bp_count", xfers.size(), 8);
    for (int i = 0; i < 8 && i < xfers.size(); i++) chk("bp_order", xfers[i], i + 1);
    drain();

    // Flush with both entries held and an add (ov=1) presented
    fill_full(16'h0011, 16'h0022);
    chk("flush_pre_full", in_ready, 0);
    drive(1'b1, 16'h0099, 3'b010, 3'b000, 1'b1, 4'h6, 1'b1, 1'b0, 3'b000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_ov_kept", flag_ov, 0);
    out_ready = 1'b1;
    drive(1'b1, 16'h00AA, 3'b000, 3'b000, 1'b0, 4'h7, 1'b1, 1'b0, 3'b000);
    step();
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_result", out_result, 16'h00AA);
    drain();

    // Simultaneous: FULL, out_ready=1 and in_valid=1
    fill_full(16'h0031, 16'h0032);
    drive(1'b1, 16'h0033, 3'b000, 3'b000, 1'b0, 4'h8, 1'b1, 1'b0, 3'b000);
    out_ready = 1'b1;
    #1 chk("sim_in_ready_low", in_ready, 0);
    step();
    chk("sim_head", out_result, 16'h0032);
    chk("sim_ready_back", in_ready, 1);
    out_ready = 1'b0;
    step();
    chk("sim_accepted_full", in_ready, 0);
    drain();

    // Reset asserted with both entries full
    fill_full(16'h0044, 16'h0055);
    reset_check();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r16 = 16'($urandom);
      be = ($urandom % 4 == 0);
      drive($urandom % 4 != 0, r16, 3'($urandom), 3'($urandom),
            be ? 1'b0 : 1'($urandom), 4'($urandom), 1'($urandom), be, 3'($urandom));
      flush = ($urandom % 16 == 0);
      out_ready = 1'($urandom);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
